fixed_vector_accumulator: RTL

- Consumes the element-wise product vectors emitted by the fixed-point vector multiplier.
- Per accepted beat: reduces the IN_SIZE lanes to one sum and accumulates it over NUM_BEATS consecutive beats, producing one signed dot-product result per group.
- Sits directly downstream of the vector multiplier in the linear/matmul datapath, on the same valid/ready streaming protocol.

---
 rtl/fixed_vector_accumulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fixed_vector_accumulator.sv
// fixed_vector_accumulator
// Reduces each accepted beat of IN_SIZE signed product lanes to one sum and
// accumulates NUM_BEATS consecutive beats into one signed dot-product result.
// Streams on valid/ready at both ends; the result is held until drained.
// Optional build macro FIXED_VECTOR_ACCUMULATOR_SUM_REG_EN registers the lane
// sum in a one-entry stage ahead of the accumulator, which adds one cycle of
// latency and leaves throughput unchanged.
module fixed_vector_accumulator #(
    parameter int IN_WIDTH  = 48,
    parameter int IN_SIZE   = 4,
    parameter int NUM_BEATS = 8,
    parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE) + $clog2(NUM_BEATS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE-1:0],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    // A single-beat group still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_beat_cnt;
    logic signed [OUT_WIDTH-1:0] r_acc;

    logic signed [OUT_WIDTH-1:0] w_sum;
    logic signed [OUT_WIDTH-1:0] w_src_sum;
    logic                        w_src_valid;
    logic                        w_take;
    logic                        w_last;

    // Sign-extend every lane to the result width and add them together.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            w_sum = w_sum + OUT_WIDTH'(data_in[i]);
        end
    end

`ifdef FIXED_VECTOR_ACCUMULATOR_SUM_REG_EN
    logic signed [OUT_WIDTH-1:0] r_sum_q;
    logic                        r_sum_valid;
    logic                        w_load;

    assign w_src_valid   = r_sum_valid;
    assign w_src_sum     = r_sum_q;
    // The stage refills in the same cycle its content moves on.
    assign data_in_ready = !r_sum_valid || w_take;
    assign w_load        = data_in_valid && data_in_ready;

    // One-entry lane-sum stage between the input port and the accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum_q     <= '0;
            r_sum_valid <= 1'b0;
        end else if (w_load) begin
            r_sum_q     <= w_sum;
            r_sum_valid <= 1'b1;
        end else if (w_take) begin
            r_sum_valid <= 1'b0;
        end
    end
`else
    assign w_src_valid   = data_in_valid;
    assign w_src_sum     = w_sum;
    // While a result is held, input only moves when the result drains.
    assign data_in_ready = (r_state == ACCUM) || data_out_ready;
`endif

    // A beat is absorbed while accumulating, or in HOLD alongside the drain.
    assign w_take = w_src_valid && ((r_state == ACCUM) || data_out_ready);
    assign w_last = (r_beat_cnt == LAST_CNT);

    assign data_out_valid = (r_state == HOLD);
    assign data_out       = r_acc;

    // Group accumulation and result hand-off state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ACCUM;
            r_beat_cnt <= '0;
            r_acc      <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_take) begin
                        r_acc <= (r_beat_cnt == '0) ? w_src_sum : r_acc + w_src_sum;
                        if (w_last) begin
                            r_beat_cnt <= '0;
                            r_state    <= HOLD;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (data_out_ready) begin
                        if (w_take) begin
                            // The beat arriving with the drain opens the next group.
                            r_acc <= w_src_sum;
                            if (NUM_BEATS == 1) begin
                                r_beat_cnt <= '0;
                                r_state    <= HOLD;
                            end else begin
                                r_beat_cnt <= CNT_W'(1);
                                r_state    <= ACCUM;
                            end
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
            endcase
        end
    end

endmodule
